// File: rtl/cnn_mul_share_arb.sv
// Round-robin sequencer time-sharing one pipelined signed x unsigned multiplier among NUM_REQ requesters.
// Define CNN_MUL_SHARE_ARB_STATS_EN to add per-requester grant counters and a stall counter.
module cnn_mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 8,
  parameter int B_W     = 13,
  parameter int P_W     = 21,
  parameter int LAT     = 2
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [P_W-1:0]         rsp_p
`ifdef CNN_MUL_SHARE_ARB_STATS_EN
  ,
  input  logic                   stat_clr,
  output logic [NUM_REQ*16-1:0]  stat_grant_cnt,
  output logic [15:0]            stat_stall_cnt
`endif
);

  logic [ID_W-1:0]           ptr_q, ptr_d;
  logic [LAT-1:0]            vld_q, vld_d;
  logic [LAT-1:0][ID_W-1:0]  id_q, id_d;
  logic [LAT-1:0][P_W-1:0]   p_q, p_d;
  logic [A_W-1:0]            a_q, a_d;
  logic [B_W-1:0]            b_q, b_d;

  logic                      stall;
  logic                      gnt_found;
  logic                      xfer;
  logic [ID_W-1:0]           gnt_idx;
  logic [A_W-1:0]            a_sel, mul_a;
  logic [B_W-1:0]            b_sel, mul_b;
  logic [P_W-1:0]            mul_p;

  assign stall = vld_q[LAT-1] & ~rsp_ready;

  // First asserted requester scanning from ptr upwards, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign xfer = gnt_found & ~stall & ap_rst_n;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = xfer && (gnt_idx == ID_W'(gi));
    end
  endgenerate

  assign a_sel = req_a[int'(gnt_idx)*A_W +: A_W];
  assign b_sel = req_b[int'(gnt_idx)*B_W +: B_W];

  // A single-stage pipe multiplies straight from the request bus; otherwise from the operand stage.
  assign mul_a = (LAT == 1) ? a_sel : a_q;
  assign mul_b = (LAT == 1) ? b_sel : b_q;
  // The exact product always fits in P_W signed bits, so P_W-wide arithmetic loses nothing.
  assign mul_p = P_W'($signed(mul_a)) * P_W'($signed({1'b0, mul_b}));

  always_comb begin
    ptr_d = xfer ? ID_W'((int'(gnt_idx) + 1) % NUM_REQ) : ptr_q;
  end

  always_comb begin
    vld_d = vld_q;
    id_d  = id_q;
    p_d   = p_q;
    a_d   = a_q;
    b_d   = b_q;
    if (!stall) begin
      vld_d[0] = xfer;
      id_d[0]  = gnt_idx;
      if (xfer) begin
        a_d = a_sel;
        b_d = b_sel;
      end
      if (LAT == 1) p_d[0] = mul_p;
      for (int s = 1; s < LAT; s++) begin
        vld_d[s] = vld_q[s-1];
        id_d[s]  = id_q[s-1];
        p_d[s]   = (s == 1) ? mul_p : p_q[s-1];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr_q <= '0;
      vld_q <= '0;
      id_q  <= '0;
      p_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      id_q  <= id_d;
      p_q   <= p_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  assign rsp_valid = vld_q[LAT-1];
  assign rsp_id    = id_q[LAT-1];
  assign rsp_p     = p_q[LAT-1];

`ifdef CNN_MUL_SHARE_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] gcnt_q, gcnt_d;
  logic [15:0]              scnt_q, scnt_d;

  // Clear dominates any same-cycle increment; counters stick at all-ones.
  always_comb begin
    gcnt_d = gcnt_q;
    scnt_d = scnt_q;
    if (stat_clr) begin
      gcnt_d = '0;
      scnt_d = '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && req_valid[i] && gcnt_q[i] != 16'hFFFF) gcnt_d[i] = gcnt_q[i] + 16'd1;
      end
      if (stall && scnt_q != 16'hFFFF) scnt_d = scnt_q + 16'd1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      gcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign stat_grant_cnt = gcnt_q;
  assign stat_stall_cnt = scnt_q;
`endif

endmodule

// File: tb/tb_cnn_mul_share_arb.sv
// Scoreboard bench for cnn_mul_share_arb: a reference arbiter predicts grants, queued products are matched on rsp.
module tb_cnn_mul_share_arb;

  localparam int N = 4;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b0;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*8-1:0]    req_a;
  logic [N*13-1:0]   req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [20:0]       rsp_p;
`ifdef CNN_MUL_SHARE_ARB_STATS_EN
  logic              stat_clr;
  logic [N*16-1:0]   stat_grant_cnt;
  logic [15:0]       stat_stall_cnt;
`endif

  logic signed [7:0] drv_a [N];
  logic [12:0]       drv_b [N];

  typedef struct { int id; int p; } exp_t;
  exp_t sb_q[$];
  exp_t m_e;
  exp_t m_got;

  int total = 0;
  int bad = 0;
  int mptr = 0;
  int m_g;
  logic m_found;
  logic m_stall;
  logic [N-1:0] m_exp;
  int hold_id, hold_p;

  always #5 ap_clk = ~ap_clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*8 +: 8]   = drv_a[i];
      req_b[i*13 +: 13] = drv_b[i];
    end
  end

  cnn_mul_share_arb dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p)
`ifdef CNN_MUL_SHARE_ARB_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_grant_cnt (stat_grant_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference arbiter and response scoreboard, sampled mid-cycle.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      mptr = 0;
      sb_q.delete();
    end else begin
      m_stall = rsp_valid && !rsp_ready;
      m_exp   = '0;
      m_found = 1'b0;
      m_g     = 0;
      if (!m_stall) begin
        for (int k = 0; k < N; k++) begin
          if (!m_found && req_valid[(mptr + k) % N]) begin
            m_found = 1'b1;
            m_g     = (mptr + k) % N;
          end
        end
      end
      if (m_found) m_exp[m_g] = 1'b1;
      chk("req_ready", int'(req_ready), int'(m_exp));
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          m_got = sb_q.pop_front();
          chk("rsp_id", int'(rsp_id), m_got.id);
          chk("rsp_p", int'($signed(rsp_p)), m_got.p);
        end
      end
      if (m_found) begin
        m_e.id = m_g;
        m_e.p  = int'(drv_a[m_g]) * int'(drv_b[m_g]);
        sb_q.push_back(m_e);
        mptr = (m_g + 1) % N;
      end
    end
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < N; i++) begin
      drv_a[i] = 8'($urandom);
      drv_b[i] = 13'($urandom);
    end
  endtask

  // One isolated request with a directly stated expected product and latency.
  task automatic single(input int idx, input int a, input int b, input int exp_p);
    drv_a[idx] = 8'(a);
    drv_b[idx] = 13'(b);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    #1;
    chk("single_ready", int'(req_ready), 1 << idx);
    step();
    req_valid = '0;
    chk("single_lat_early", int'(rsp_valid), 0);
    step();
    chk("single_lat_valid", int'(rsp_valid), 1);
    chk("single_id", int'(rsp_id), idx);
    chk("single_p", int'($signed(rsp_p)), exp_p);
    step();
  endtask

  initial begin
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      drv_a[i] = '0;
      drv_b[i] = '0;
    end
`ifdef CNN_MUL_SHARE_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    #12;
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_valid", int'(rsp_valid), 0);
    chk("rst_id", int'(rsp_id), 0);
    chk("rst_p", int'(rsp_p), 0);
    req_valid = '0;
    step();
    ap_rst_n = 1'b1;
    step();

    single(2, -3, 100, -300);
    single(0, -128, 8191, -1048448);
    single(1, 127, 8191, 1040257);
    single(3, 0, 8191, 0);

    // All requesters busy: continuous accepts, no bubbles on the response side.
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      randomize_ops();
      step();
      if (c >= 1) chk("stream_no_bubble", int'(rsp_valid), 1);
    end

    // Backpressure for five cycles while the pipe is full.
    randomize_ops();
    rsp_ready = 1'b0;
    #1;
    hold_id = int'(rsp_id);
    hold_p  = int'($signed(rsp_p));
    for (int c = 0; c < 5; c++) begin
      chk("bp_ready", int'(req_ready), 0);
      step();
      chk("bp_valid", int'(rsp_valid), 1);
      chk("bp_id_stable", int'(rsp_id), hold_id);
      chk("bp_p_stable", int'($signed(rsp_p)), hold_p);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    repeat (4) step();
    chk("bp_drain", sb_q.size(), 0);

    // Reset with two products in flight.
    req_valid = '1;
    randomize_ops();
    step();
    randomize_ops();
    step();
    chk("rm_valid_pre", int'(rsp_valid), 1);
    ap_rst_n = 1'b0;
    #1;
    chk("rm_valid_drop", int'(rsp_valid), 0);
    chk("rm_ready_drop", int'(req_ready), 0);
    step();
    ap_rst_n = 1'b1;
    #1;
    chk("rm_first_gnt", int'(req_ready), 1);
    for (int c = 0; c < 4; c++) begin
      randomize_ops();
      step();
    end
    req_valid = '0;
    repeat (4) step();
    chk("rm_drain", sb_q.size(), 0);

`ifdef CNN_MUL_SHARE_ARB_STATS_EN
    chk("st_g0", int'(stat_grant_cnt[15:0]), 1);
    req_valid = 4'b0010;
    repeat (70000) @(posedge ap_clk);
    #1;
    req_valid = '0;
    chk("st_g1_sat", int'(stat_grant_cnt[31:16]), 16'hFFFF);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("st_g1_clr", int'(stat_grant_cnt[31:16]), 0);
    chk("st_stall_clr", int'(stat_stall_cnt), 0);
    repeat (4) step();
`endif

    chk("final_drain", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
